waveform_player: RTL and testbench

//  Parametrised waveform sequencer with an internal single-clock dual-port RAM, supporting one-shot, continuous-loop and N-burst playback.
//  A host writes samples through the write port. An external trigger starts playback, and each i_wf_set_flag tick advances one sample.
//  o_wf_sp feeds the MPS Core set point. The block keeps the current sample or the last sample until the next trigger or disable.

---
 rtl/waveform_player.sv | 250 +++++++++++++++++++++++++
 tb/tb_waveform_player.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_player.sv
// -----------------------------------------------------------------------------
// waveform_player
//
// Waveform sequencer with an internal single-clock dual-port RAM. A host fills
// the RAM through the write port. A rising edge on the external trigger starts
// playback. Each i_wf_set_flag tick then advances one sample, and the selected
// sample is driven on o_wf_sp as the MPS Core set point.
//
// Playback modes (latched at the trigger):
//   00 / 11  one-shot : play len samples once, then hold the last sample
//   01       loop     : replay len samples forever, counting passes
//   10       burst    : play rep passes of len samples, then hold the last one
//
// Ports
//   i_clk          clock; all logic runs in this domain
//   i_rst          synchronous active-low reset
//   i_wr_en        host write strobe
//   i_wr_addr      host write address (writes at or above DEPTH are dropped)
//   i_wr_data      host write data
//   i_en           player enable; low forces IDLE with a zero set point
//   i_mode         playback mode, latched at trigger
//   i_wf_len       samples per pass, latched at trigger (0 -> 1, clamped to DEPTH)
//   i_rep_num      passes in burst mode, latched at trigger (0 -> 1)
//   i_wf_trg       external trigger, asynchronous to i_clk
//   i_wf_set_flag  one-cycle step tick
//   o_wf_sp        set-point sample (registered RAM read of the current index)
//   o_active       player is not IDLE
//   o_busy         player is in RUN
//   o_done         one-cycle pulse on the edge that enters HOLD
//   o_wf_idx       current sample index
//   o_pass_cnt     completed passes, saturating at all-ones
// -----------------------------------------------------------------------------
module waveform_player #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 100000,
  parameter int AWIDTH = $clog2(DEPTH),
  parameter int RWIDTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [AWIDTH-1:0] i_wr_addr,
  input  logic [DWIDTH-1:0] i_wr_data,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic [AWIDTH-1:0] i_wf_len,
  input  logic [RWIDTH-1:0] i_rep_num,
  input  logic              i_wf_trg,
  input  logic              i_wf_set_flag,
  output logic [DWIDTH-1:0] o_wf_sp,
  output logic              o_active,
  output logic              o_busy,
  output logic              o_done,
  output logic [AWIDTH-1:0] o_wf_idx,
  output logic [RWIDTH-1:0] o_pass_cnt
);

  // Depth expressed one bit wider than the address so that lengths and
  // addresses can be compared against it even when DEPTH == 2**AWIDTH.
  localparam logic [AWIDTH:0]   DEPTH_X = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] MAX_IDX = AWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PM_ONESHOT = 2'd0,
    PM_LOOP    = 2'd1,
    PM_BURST   = 2'd2
  } play_mode_t;

  // ---------------------------------------------------------------------------
  // Trigger synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  logic trg_s1, trg_s2, trg_s2_d;
  logic trg_rise;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      trg_s1   <= 1'b0;
      trg_s2   <= 1'b0;
      trg_s2_d <= 1'b0;
    end else begin
      trg_s1   <= i_wf_trg;
      trg_s2   <= trg_s1;
      trg_s2_d <= trg_s2;
    end
  end

  assign trg_rise = trg_s2 & ~trg_s2_d;

  // ---------------------------------------------------------------------------
  // Configuration decode (values captured only on a trigger)
  // ---------------------------------------------------------------------------
  // The pass length is kept as its last index (len - 1) so that a full-depth
  // pass still fits in AWIDTH bits.
  logic [AWIDTH-1:0] last_in;
  logic [RWIDTH-1:0] rep_last_in;
  play_mode_t        mode_in;

  always_comb begin
    if (i_wf_len == '0) begin
      last_in = '0;
    end else if ({1'b0, i_wf_len} > DEPTH_X) begin
      last_in = MAX_IDX;
    end else begin
      last_in = i_wf_len - AWIDTH'(1);
    end
  end

  assign rep_last_in = (i_rep_num == '0) ? '0 : (i_rep_num - RWIDTH'(1));

  always_comb begin
    case (i_mode)
      2'b01:   mode_in = PM_LOOP;
      2'b10:   mode_in = PM_BURST;
      default: mode_in = PM_ONESHOT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Player FSM
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [AWIDTH-1:0] idx_q, idx_d;
  logic [RWIDTH-1:0] pass_q, pass_d;
  logic              done_q, done_d;
  logic [AWIDTH-1:0] last_q, last_d;
  logic [RWIDTH-1:0] rep_last_q, rep_last_d;
  play_mode_t        mode_q, mode_d;
  logic [RWIDTH-1:0] pass_inc;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pass_q     <= '0;
      done_q     <= 1'b0;
      last_q     <= '0;
      rep_last_q <= '0;
      mode_q     <= PM_ONESHOT;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
      last_q     <= last_d;
      rep_last_q <= rep_last_d;
      mode_q     <= mode_d;
    end
  end

  // Pass counter saturates instead of wrapping in long loop runs.
  assign pass_inc = (&pass_q) ? pass_q : (pass_q + RWIDTH'(1));

  // Priority: disable, then trigger, then step tick.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    state_d    = state_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    last_d     = last_q;
    rep_last_d = rep_last_q;
    mode_d     = mode_q;

    if (!i_en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (trg_rise) begin
      // Trigger from any state restarts playback with fresh configuration.
      state_d    = ST_RUN;
      idx_d      = '0;
      pass_d     = '0;
      last_d     = last_in;
      rep_last_d = rep_last_in;
      mode_d     = mode_in;
    end else if (state_q == ST_RUN && i_wf_set_flag) begin
      if (idx_q != last_q) begin
        idx_d = idx_q + AWIDTH'(1);
      end else begin
        // End of a pass.
        case (mode_q)
          PM_LOOP: begin
            idx_d  = '0;
            pass_d = pass_inc;
          end
          PM_BURST: begin
            pass_d = pass_inc;
            if (pass_q == rep_last_q) begin
              state_d = ST_HOLD;
              done_d  = 1'b1;
            end else begin
              idx_d = '0;
            end
          end
          default: begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample RAM: write port for the host, registered read-first read port
  // ---------------------------------------------------------------------------
  logic [DWIDTH-1:0] mem [DEPTH];
  logic              wr_ok;
  logic [DWIDTH-1:0] sp_q;

  assign wr_ok = i_wr_en && ({1'b0, i_wr_addr} < DEPTH_X);

  // NOTE: the sample array has no reset; clearing it would take DEPTH cycles
  // of logic and prevent mapping onto block RAM. Host data survives reset.
  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Output register of the RAM. It samples the index from before the edge,
  // so a same-cycle write to that address returns the old word. The zeroing
  // terms use the pre-edge state, giving the one-edge lag after RUN entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst || !i_en || state_q == ST_IDLE) begin
      sp_q <= '0;
    end else begin
      sp_q <= mem[idx_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_wf_sp    = sp_q;
  assign o_active   = (state_q != ST_IDLE);
  assign o_busy     = (state_q == ST_RUN);
  assign o_done     = done_q;
  assign o_wf_idx   = idx_q;
  assign o_pass_cnt = pass_q;

endmodule

// File: tb/tb_waveform_player.sv
// -----------------------------------------------------------------------------
// tb_waveform_player
//
// Directed bench for waveform_player. A behavioural model, stepped on every
// rising clock edge from the same inputs the DUT sees, predicts all outputs;
// a compare process checks them on every falling edge. Literal expectations
// placed along the stimulus pin the model to hand-derived values.
// -----------------------------------------------------------------------------
module tb_waveform_player;

  localparam int DW    = 32;
  localparam int DEPTH = 20;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          i_en;
  logic [1:0]    i_mode;
  logic [AW-1:0] i_wf_len;
  logic [RW-1:0] i_rep_num;
  logic          i_wf_trg;
  logic          i_wf_set_flag;
  logic [DW-1:0] o_wf_sp;
  logic          o_active;
  logic          o_busy;
  logic          o_done;
  logic [AW-1:0] o_wf_idx;
  logic [RW-1:0] o_pass_cnt;

  waveform_player #(
    .DWIDTH(DW),
    .DEPTH (DEPTH),
    .AWIDTH(AW),
    .RWIDTH(RW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_en         (i_en),
    .i_mode       (i_mode),
    .i_wf_len     (i_wf_len),
    .i_rep_num    (i_rep_num),
    .i_wf_trg     (i_wf_trg),
    .i_wf_set_flag(i_wf_set_flag),
    .o_wf_sp      (o_wf_sp),
    .o_active     (o_active),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_wf_idx     (o_wf_idx),
    .o_pass_cnt   (o_pass_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   phase: 0 = idle, 1 = playing, 2 = holding last sample
  //   trigger history: trg_hist[0] is the sample taken at the previous edge;
  //   a start is recognised two edges after the first high sample.
  // ---------------------------------------------------------------------------
  int  mem_m [DEPTH];
  bit  trg_hist [$] = '{1'b0, 1'b0, 1'b0};
  bit  model_on = 1'b0;
  int  m_phase = 0, m_idx = 0, m_pass = 0, m_len = 1, m_reps = 1, m_mode = 0;
  int  m_sp = 0;
  bit  m_done = 1'b0;
  bit  m_rise;
  int  m_next_sp;
  localparam int PASS_MAX = (1 << RW) - 1;

  always @(posedge i_clk) begin
    m_rise    = trg_hist[1] && !trg_hist[2];
    m_next_sp = (i_rst && i_en && m_phase != 0) ? mem_m[m_idx] : 0;
    if (i_wr_en && int'(i_wr_addr) < DEPTH) mem_m[i_wr_addr] = int'(i_wr_data);
    m_sp   = m_next_sp;
    m_done = 1'b0;
    if (!i_rst) begin
      m_phase  = 0;
      m_idx    = 0;
      m_pass   = 0;
      trg_hist = '{1'b0, 1'b0, 1'b0};
      model_on = 1'b1;
    end else begin
      trg_hist.push_front(i_wf_trg);
      void'(trg_hist.pop_back());
      if (!i_en) begin
        m_phase = 0;
        m_idx   = 0;
      end else if (m_rise) begin
        m_phase = 1;
        m_idx   = 0;
        m_pass  = 0;
        m_len   = (i_wf_len == 0) ? 1 : ((int'(i_wf_len) > DEPTH) ? DEPTH : int'(i_wf_len));
        m_reps  = (i_rep_num == 0) ? 1 : int'(i_rep_num);
        m_mode  = int'(i_mode);
      end else if (m_phase == 1 && i_wf_set_flag) begin
        if (m_idx < m_len - 1) begin
          m_idx++;
        end else if (m_mode == 1 || (m_mode == 2 && m_pass != m_reps - 1)) begin
          m_idx = 0;
          if (m_pass < PASS_MAX) m_pass++;
        end else begin
          m_phase = 2;
          m_done  = 1'b1;
          if (m_mode == 2 && m_pass < PASS_MAX) m_pass++;
        end
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge i_clk) begin
    if (model_on) begin
      check("cmp_sp",     64'(o_wf_sp),    64'(m_sp));
      check("cmp_active", 64'(o_active),   64'(m_phase != 0));
      check("cmp_busy",   64'(o_busy),     64'(m_phase == 1));
      check("cmp_done",   64'(o_done),     64'(m_done));
      check("cmp_idx",    64'(o_wf_idx),   64'(m_idx));
      check("cmp_pass",   64'(o_pass_cnt), 64'(m_pass));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    i_wr_en   = 1'b1;
    i_wr_addr = AW'(a);
    i_wr_data = DW'(d);
    step();
    i_wr_en   = 1'b0;
  endtask

  // Returns just after the edge that enters RUN.
  task automatic trigger();
    i_wf_trg = 1'b1;
    step();
    i_wf_trg = 1'b0;
    step();
    step();
  endtask

  task automatic flag();
    i_wf_set_flag = 1'b1;
    step();
    i_wf_set_flag = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] mode, input int len, input int rep);
    i_mode    = mode;
    i_wf_len  = AW'(len);
    i_rep_num = RW'(rep);
  endtask

  int exp_burst [6] = '{101, 102, 100, 101, 102, 102};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b0; i_en = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_wf_trg = 1'b0; i_wf_set_flag = 1'b0;
    cfg(2'b00, 0, 0);
    step();
    step();
    check("rst_sp",     64'(o_wf_sp),    64'd0);
    check("rst_active", 64'(o_active),   64'd0);
    check("rst_busy",   64'(o_busy),     64'd0);
    check("rst_idx",    64'(o_wf_idx),   64'd0);
    i_rst = 1'b1;
    step();

    for (int i = 0; i < DEPTH; i++) wr(i, i + 100);
    i_en = 1'b1;

    // 1: one-shot, len 8
    cfg(2'b00, 8, 0);
    trigger();
    check("t1_entry_busy", 64'(o_busy), 64'd1);
    check("t1_entry_idx",  64'(o_wf_idx), 64'd0);
    step();
    check("t1_first_sp", 64'(o_wf_sp), 64'd100);
    for (int i = 1; i <= 8; i++) begin
      flag();
      if (i == 8) begin
        check("t1_done",     64'(o_done),   64'd1);
        check("t1_hold_idx", 64'(o_wf_idx), 64'd7);
      end
      step();
      check("t1_sp", 64'(o_wf_sp), 64'((i < 7) ? 100 + i : 107));
    end
    check("t1_hold_busy",   64'(o_busy),   64'd0);
    check("t1_hold_active", 64'(o_active), 64'd1);

    // Read-first on a same-cycle write to the address being read.
    i_wr_en = 1'b1; i_wr_addr = AW'(7); i_wr_data = DW'(777);
    step();
    i_wr_en = 1'b0;
    check("rf_old", 64'(o_wf_sp), 64'd107);
    step();
    check("rf_new", 64'(o_wf_sp), 64'd777);
    wr(7, 107);
    step();

    // 2: loop, len 4
    cfg(2'b01, 4, 0);
    trigger();
    step();
    for (int i = 1; i <= 10; i++) begin
      flag();
      step();
      if (i == 9) begin
        check("t2_sp9",   64'(o_wf_sp),    64'd101);
        check("t2_pass9", 64'(o_pass_cnt), 64'd2);
      end
    end
    check("t2_sp10",   64'(o_wf_sp),    64'd102);
    check("t2_pass10", 64'(o_pass_cnt), 64'd2);

    // 3: burst, len 3, 2 passes
    cfg(2'b10, 3, 2);
    trigger();
    step();
    check("t3_first", 64'(o_wf_sp), 64'd100);
    for (int i = 1; i <= 6; i++) begin
      flag();
      if (i == 6) check("t3_done", 64'(o_done), 64'd1);
      step();
      check("t3_sp", 64'(o_wf_sp), 64'(exp_burst[i-1]));
    end
    check("t3_pass", 64'(o_pass_cnt), 64'd2);
    check("t3_busy", 64'(o_busy),     64'd0);

    // 4: retrigger at idx 5
    cfg(2'b00, 8, 0);
    trigger();
    step();
    for (int i = 0; i < 5; i++) begin
      flag();
      step();
    end
    check("t4_idx5", 64'(o_wf_idx), 64'd5);
    trigger();
    check("t4_idx0",   64'(o_wf_idx), 64'd0);
    check("t4_sp_old", 64'(o_wf_sp),  64'd105);
    step();
    check("t4_sp100",  64'(o_wf_sp),  64'd100);

    // 5: len 0 -> one sample; len beyond DEPTH clamps; disable mid-run
    cfg(2'b00, 0, 0);
    trigger();
    step();
    check("t5_len0_sp", 64'(o_wf_sp), 64'd100);
    flag();
    check("t5_len0_done", 64'(o_done),   64'd1);
    check("t5_len0_idx",  64'(o_wf_idx), 64'd0);
    step();
    cfg(2'b01, DEPTH + 5, 0);
    trigger();
    step();
    for (int i = 0; i < DEPTH - 1; i++) begin
      flag();
      step();
    end
    check("t5_last_idx", 64'(o_wf_idx), 64'(DEPTH - 1));
    check("t5_last_sp",  64'(o_wf_sp),  64'(DEPTH - 1 + 100));
    flag();
    check("t5_wrap_idx",  64'(o_wf_idx),   64'd0);
    check("t5_wrap_pass", 64'(o_pass_cnt), 64'd1);
    step();
    check("t5_wrap_sp", 64'(o_wf_sp), 64'd100);
    flag();
    flag();
    i_en = 1'b0;
    step();
    check("t5_dis_sp",     64'(o_wf_sp),  64'd0);
    check("t5_dis_active", 64'(o_active), 64'd0);
    check("t5_dis_idx",    64'(o_wf_idx), 64'd0);
    i_en = 1'b1;
    step();

    // 6: trigger beats a same-edge step; out-of-range write; reset mid-run
    cfg(2'b01, 8, 0);
    trigger();
    step();
    for (int i = 0; i < 3; i++) begin
      flag();
      step();
    end
    i_wf_trg = 1'b1;
    step();
    i_wf_trg = 1'b0;
    step();
    i_wf_set_flag = 1'b1;
    step();
    i_wf_set_flag = 1'b0;
    check("t6_trig_wins_idx",  64'(o_wf_idx), 64'd0);
    check("t6_trig_wins_busy", 64'(o_busy),   64'd1);
    step();
    check("t6_sp100", 64'(o_wf_sp), 64'd100);
    wr(DEPTH, 999);
    wr(31, 999);
    flag();
    flag();
    step();
    i_rst = 1'b0;
    step();
    check("t6_rst_sp",     64'(o_wf_sp),    64'd0);
    check("t6_rst_active", 64'(o_active),   64'd0);
    check("t6_rst_busy",   64'(o_busy),     64'd0);
    check("t6_rst_done",   64'(o_done),     64'd0);
    check("t6_rst_idx",    64'(o_wf_idx),   64'd0);
    check("t6_rst_pass",   64'(o_pass_cnt), 64'd0);
    i_rst = 1'b1;
    step();
    cfg(2'b00, DEPTH, 0);
    trigger();
    step();
    check("t6_mem_kept0", 64'(o_wf_sp), 64'd100);
    for (int i = 1; i < DEPTH; i++) begin
      flag();
      step();
    end
    check("t6_mem_kept_last", 64'(o_wf_sp), 64'(DEPTH - 1 + 100));

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
